// File: rtl/img_feed_pkg.sv
// Shared types and constants for the image row feeder: FSM state encoding,
// pixel width, default frame geometry and small state-class helpers.
package img_feed_pkg;

    localparam int PIX_W            = 8;
    localparam int DEF_IMG_W        = 512;
    localparam int DEF_IMG_H        = 512;
    localparam int DEF_PRELOAD_ROWS = 4;

    typedef enum logic [3:0] {
        IDLE,
        PRELOAD,
        WAIT_TOP,
        PAD_TOP,
        WAIT_ROW,
        ROW,
        WAIT_BOT,
        PAD_BOT,
        DONE
    } feed_state_e;

    // States that pull pixels from the source FIFO.
    function automatic logic is_src_state(input feed_state_e s);
        return (s == PRELOAD) || (s == ROW);
    endfunction

    function automatic logic is_pad_state(input feed_state_e s);
        return (s == PAD_TOP) || (s == PAD_BOT);
    endfunction

    function automatic logic is_idle_state(input feed_state_e s);
        return (s == IDLE) || (s == DONE);
    endfunction

endpackage

// File: rtl/intr_edge_latch.sv
// Core interrupt edge detector: registers intr twice, turns a rising edge into
// a pending flag, and raises a sticky overflow if an edge lands on a pending one.
module intr_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic intr,
    input  logic consume,
    output logic pend,
    output logic err_ovf
);

    logic intr_q,  intr_d;
    logic intr2_q, intr2_d;
    logic pend_q,  pend_d;
    logic err_q,   err_d;
    logic edge_det;

    always_comb begin
        intr_d   = intr;
        intr2_d  = intr_q;
        edge_det = intr_q & ~intr2_q;
        pend_d   = pend_q;
        if (consume) begin
            pend_d = 1'b0;
        end
        // An edge coinciding with consumption re-arms pend, so it is never lost.
        if (edge_det) begin
            pend_d = 1'b1;
        end
        err_d = err_q | (edge_det & pend_q & ~consume);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            intr_q  <= 1'b0;
            intr2_q <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            intr_q  <= intr_d;
            intr2_q <= intr2_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign pend    = pend_q;
    assign err_ovf = err_q;

endmodule

// File: rtl/image_row_feeder.sv
// Feeds the 3x3 filter core: preload rows, zero/pad top row, one row per core
// interrupt, pad bottom row. Output registered (1 cycle after source handshake).
// Optional FEEDER_PAD_PORT_EN adds a pad_value input sampled at frame start.
module image_row_feeder
    import img_feed_pkg::*;
#(
    parameter int IMG_W        = DEF_IMG_W,
    parameter int IMG_H        = DEF_IMG_H,
    parameter int PRELOAD_ROWS = DEF_PRELOAD_ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef FEEDER_PAD_PORT_EN
    input  logic [PIX_W-1:0] pad_value,
`endif
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_data,
    output logic             src_ready,
    input  logic             intr,
    output logic             out_valid,
    output logic [PIX_W-1:0] out_data,
    output logic             busy,
    output logic             done,
    output logic             err_ovf
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] PRE_LAST = ROW_W'(PRELOAD_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_TOT  = ROW_W'(IMG_H);

    feed_state_e      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             tail_q, tail_d;
    logic             out_valid_q, out_valid_d;
    logic [PIX_W-1:0] out_data_q, out_data_d;

    logic             start_ok;
    logic             src_fire;
    logic             pad_fire;
    logic             col_end;
    logic             consume;
    logic             pend;
    logic [PIX_W-1:0] pad_val;

    intr_edge_latch u_intr (
        .clk     (clk),
        .rst     (rst),
        .intr    (intr),
        .consume (consume),
        .pend    (pend),
        .err_ovf (err_ovf)
    );

    assign start_ok = start && is_idle_state(state_q);

`ifdef FEEDER_PAD_PORT_EN
    logic [PIX_W-1:0] pad_q, pad_d;

    always_comb begin
        pad_d = pad_q;
        if (start_ok) begin
            pad_d = pad_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pad_q <= '0;
        end else begin
            pad_q <= pad_d;
        end
    end

    assign pad_val = pad_q;
`else
    assign pad_val = '0;
`endif

    // tail_q marks the one idle cycle that closes every transfer.
    assign src_ready = is_src_state(state_q) && !tail_q;
    assign src_fire  = src_ready && src_valid;
    assign pad_fire  = is_pad_state(state_q) && !tail_q;
    assign col_end   = (col_q == COL_LAST);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        tail_d      = tail_q;
        consume     = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = '0;

        if (src_fire || pad_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = src_fire ? src_data : pad_val;
            col_d       = col_end ? '0 : col_q + COL_W'(1);
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = PRELOAD;
                    col_d   = '0;
                    row_d   = '0;
                    tail_d  = 1'b0;
                end
            end
            PRELOAD: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = WAIT_TOP;
                end else if (src_fire && col_end) begin
                    row_d = row_q + ROW_W'(1);
                    if (row_q == PRE_LAST) begin
                        tail_d = 1'b1;
                    end
                end
            end
            ROW, PAD_TOP: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = (row_q < ROW_TOT) ? WAIT_ROW : WAIT_BOT;
                end else if ((src_fire || pad_fire) && col_end) begin
                    tail_d = 1'b1;
                    if (state_q == ROW) begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            PAD_BOT: begin
                if (tail_q) begin
                    tail_d  = 1'b0;
                    state_d = DONE;
                end else if (pad_fire && col_end) begin
                    tail_d = 1'b1;
                end
            end
            WAIT_TOP: begin
                if (pend) begin
                    consume = 1'b1;
                    state_d = PAD_TOP;
                end
            end
            WAIT_ROW: begin
                if (pend) begin
                    consume = 1'b1;
                    state_d = ROW;
                end
            end
            WAIT_BOT: begin
                if (pend) begin
                    consume = 1'b1;
                    state_d = PAD_BOT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            tail_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tail_q      <= tail_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = !is_idle_state(state_q);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_image_row_feeder.sv
// Directed bench for image_row_feeder (8x6 frame, 4 preload rows) with a
// scoreboard of expected core-side pixels; honours FEEDER_PAD_PORT_EN.
module tb_image_row_feeder;

    localparam int W = 8;
    localparam int H = 6;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       src_valid = 1'b0;
    logic [7:0] src_data = 8'h00;
    logic       src_ready;
    logic       intr = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic       err_ovf;
`ifdef FEEDER_PAD_PORT_EN
    logic [7:0] pad_value = 8'h00;
`endif

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         out_cnt = 0;
    int         idle_run = 0;
    int         gap_before[0:511];
    logic       src_en = 1'b0;
    logic       src_half = 1'b0;
    logic       tog = 1'b0;
    logic [7:0] next_pix = 8'h01;
    logic [7:0] pad_exp = 8'h00;

    always #5 clk = ~clk;

    image_row_feeder #(.IMG_W(W), .IMG_H(H), .PRELOAD_ROWS(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef FEEDER_PAD_PORT_EN
        .pad_value (pad_value),
`endif
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .intr      (intr),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err_ovf   (err_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Source FIFO model: accepted pixels become expected core outputs.
    always @(negedge clk) begin
        tog = ~tog;
        if (src_en && (!src_half || tog)) begin
            src_valid = 1'b1;
            src_data  = next_pix;
        end else begin
            src_valid = 1'b0;
        end
        #1;
        if (src_valid && src_ready) begin
            exp_q.push_back(src_data);
            next_pix = next_pix + 8'd1;
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin
            if (out_cnt < 512) gap_before[out_cnt] = idle_run;
            idle_run = 0;
            chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk($sformatf("pix_%0d", out_cnt), {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            out_cnt++;
        end else begin
            idle_run++;
        end
    end

    task automatic wait_out(input int n);
        int k = 0;
        while (out_cnt < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk($sformatf("reach_%0d_outputs", n), {31'd0, out_cnt >= n}, 32'd1);
    endtask

    task automatic pulse_intr();
        @(negedge clk) intr = 1'b1;
        @(negedge clk) intr = 1'b0;
    endtask

    task automatic push_pad();
        for (int i = 0; i < W; i++) exp_q.push_back(pad_exp);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic check_end(input logic err_exp);
        repeat (3) @(negedge clk);
        chk("done", {31'd0, done}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("err_ovf_end", {31'd0, err_ovf}, {31'd0, err_exp});
        chk("frame_outputs", out_cnt, 32'(W * (H + 2)));
        chk("sb_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err_ovf}, 32'd0);
        chk("rst_src_ready", {31'd0, src_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;

        // Frame A: full frame, source always valid, early intr during PAD_TOP
        out_cnt = 0; src_half = 1'b0; src_en = 1'b1; pad_exp = 8'h00;
        do_start();
        wait_out(P * W);
        repeat (4) @(negedge clk);
        chk("preload_hold_cnt", out_cnt, 32'(P * W));
        chk("wait_top_src_ready", {31'd0, src_ready}, 32'd0);
        push_pad();
        pulse_intr();
        wait_out(P * W + 1);
        pulse_intr();
        wait_out(P * W + W + 1);
        chk("wait_row_gap", gap_before[P * W + W], 32'd2);
        chk("early_intr_no_err", {31'd0, err_ovf}, 32'd0);
        wait_out(P * W + 2 * W);
        pulse_intr();
        wait_out(P * W + 3 * W);
        push_pad();
        pulse_intr();
        wait_out(W * (H + 2));
        check_end(1'b0);

        // Frame B: half-rate source, double intr edge inside one row
        out_cnt = 0; src_half = 1'b1;
`ifdef FEEDER_PAD_PORT_EN
        pad_value = 8'hFF; pad_exp = 8'hFF;
`endif
        do_start();
`ifdef FEEDER_PAD_PORT_EN
        pad_value = 8'h5A;
`endif
        wait_out(P * W);
        repeat (4) @(negedge clk);
        chk("preload_half_cnt", out_cnt, 32'(P * W));
        push_pad();
        pulse_intr();
        wait_out(P * W + W);
        pulse_intr();
        wait_out(P * W + W + 1);
        pulse_intr();
        @(negedge clk);
        pulse_intr();
        repeat (4) @(negedge clk);
        chk("double_edge_err", {31'd0, err_ovf}, 32'd1);
        wait_out(P * W + 3 * W);
        push_pad();
        pulse_intr();
        wait_out(W * (H + 2));
        check_end(1'b1);

        // Frame C: reset mid-ROW
        out_cnt = 0; src_half = 1'b0;
`ifdef FEEDER_PAD_PORT_EN
        pad_value = 8'h00;
`endif
        pad_exp = 8'h00;
        do_start();
        wait_out(P * W);
        push_pad();
        pulse_intr();
        wait_out(P * W + W);
        pulse_intr();
        wait_out(P * W + W + 3);
        @(negedge clk) src_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_row_busy", {31'd0, busy}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_err", {31'd0, err_ovf}, 32'd0);
        chk("abort_src_ready", {31'd0, src_ready}, 32'd0);
        @(negedge clk) rst = 1'b0;
        chk("abort_sb_empty", exp_q.size(), 32'd0);

        // Frame D: restart after abort
        out_cnt = 0; src_en = 1'b1;
        do_start();
        wait_out(P * W);
        push_pad();
        pulse_intr();
        wait_out(P * W + W);
        pulse_intr();
        wait_out(P * W + 2 * W);
        pulse_intr();
        wait_out(P * W + 3 * W);
        push_pad();
        pulse_intr();
        wait_out(W * (H + 2));
        check_end(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
